// File: rtl/mips_pkg.sv
// mips_pkg: shared front-end types, instruction field positions and fetch constants
package mips_pkg;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2,
    S_KILL = 2'd3
  } fetch_state_e;
  localparam logic [31:0] NOP       = 32'h0000_0000;
  localparam int          OPC_MSB   = 31;
  localparam int          OPC_LSB   = 26;
  localparam int          FUNCT_MSB = 5;
  localparam int          FUNCT_LSB = 0;
  localparam logic [31:0] PC_INC    = 32'd4;
endpackage

// File: rtl/ifid_skid.sv
// ifid_skid: single-entry buffer for a word fetched while IF/ID is stalled
module ifid_skid import mips_pkg::*; (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        drain_i,
  input  logic        inval_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc4_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc4_o
);
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d, pc4_q, pc4_d;
  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc4_o   = pc4_q;
  // invalidate overrides load, load overrides drain
  always_comb begin
    valid_d = inval_i ? 1'b0 : load_i ? 1'b1 : drain_i ? 1'b0 : valid_q;
    instr_d = (load_i && !inval_i) ? instr_i : instr_q;
    pc4_d   = (load_i && !inval_i) ? pc4_i : pc4_q;
  end
  // entry storage, emptied asynchronously on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      instr_q <= NOP;
      pc4_q   <= 32'h0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, instruction-memory req/ack fetch FSM and IF/ID register feeding decoder_mips
module fetch_stage import mips_pkg::*; #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc4,
  output logic [5:0]  opcode,
  output logic [5:0]  funct
);
  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d, kaddr_q, kaddr_d, instr_q, instr_d, pc4_q, pc4_d;
  logic         valid_q, valid_d;
  logic         skid_load, skid_drain, skid_valid;
  logic [31:0]  skid_instr, skid_pc4, pc_next, target;
  assign pc_next   = pc_q + PC_INC;
  assign target    = branch_target & 32'hFFFF_FFFC;
  assign imem_req  = state_q == S_REQ || state_q == S_KILL;
  assign imem_addr = state_q == S_KILL ? kaddr_q : pc_q;
  assign if_valid  = valid_q;
  assign if_instr  = valid_q ? instr_q : NOP;
  assign if_pc4    = pc4_q;
  assign opcode    = if_instr[OPC_MSB:OPC_LSB];
  assign funct     = if_instr[FUNCT_MSB:FUNCT_LSB];
  ifid_skid u_skid (
    .clk     (clk),
    .rst     (rst),
    .load_i  (skid_load),
    .drain_i (skid_drain),
    .inval_i (branch_taken),
    .instr_i (imem_rdata),
    .pc4_i   (pc_next),
    .valid_o (skid_valid),
    .instr_o (skid_instr),
    .pc4_o   (skid_pc4)
  );
  // next state: a redirect wins over stall and every per-state action
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    kaddr_d    = kaddr_q;
    valid_d    = valid_q;
    instr_d    = instr_q;
    pc4_d      = pc4_q;
    skid_load  = 1'b0;
    skid_drain = 1'b0;
    if (branch_taken) begin
      pc_d    = target;
      valid_d = 1'b0;
      state_d = (state_q == S_KILL || (state_q == S_REQ && !imem_ack)) ? S_KILL : S_REQ;
      kaddr_d = state_q == S_REQ ? pc_q : kaddr_q;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_REQ;
        S_REQ: begin
          if (imem_ack && valid_q && stall) begin
            skid_load = 1'b1;
            pc_d      = pc_next;
            state_d   = S_HOLD;
          end else if (imem_ack) begin
            valid_d = 1'b1;
            instr_d = imem_rdata;
            pc4_d   = pc_next;
            pc_d    = pc_next;
          end else if (!stall) begin
            valid_d = 1'b0;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            skid_drain = 1'b1;
            valid_d    = skid_valid;
            instr_d    = skid_instr;
            pc4_d      = skid_pc4;
            state_d    = S_REQ;
          end
        end
        default: state_d = imem_ack ? S_REQ : S_KILL;
      endcase
    end
  end
  // FSM, PC and IF/ID registers, all returned to reset values asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      kaddr_q <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= NOP;
      pc4_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      kaddr_q <= kaddr_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
    end
  end
endmodule
